lane_traffic_engine: RTL and testbench



---
 rtl/lane_traffic_engine.sv | 194 +++++++++++++++++++
 tb/tb_lane_traffic_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_traffic_engine.sv
// -----------------------------------------------------------------------------
// lane_traffic_engine
//
// Traffic and log engine for the Frogger playfield. It owns NUM_LANES
// horizontal lanes of OBJ_PER_LANE objects each. Every lane is either a road
// lane (cars, CAR_LEN tiles) or a water lane (logs, LOG_LEN tiles). Each lane
// has its own step period and direction. The period shrinks as the level rises.
//
// Ports
//   i_Clk, i_Rst_L        clock, asynchronous active-low reset
//   i_Frame_Tick          one-cycle pulse per video frame
//   i_Enable              1 = lanes advance on ticks, 0 = frozen (ticks dropped)
//   i_Restart             synchronous restore of initial positions/counters
//   i_Level               current level, sampled every cycle
//   i_Query_Col/Row       renderer tile query
//   o_Query_Hit/Water     registered query answer (1-cycle latency)
//   i_Frog_X/Y            frog tile position
//   o_Frog_Collided       frog on a road tile covered by a car (registered)
//   o_Frog_On_Log         frog on a water tile covered by a log (registered)
//   o_Frog_Drown          frog on a water tile with no log (registered)
//   o_Carry_Step/Dir      one-cycle pulse: the frog's log stepped, and its way
//
// There is no handshake: every input is sampled on every rising edge and every
// output is a plain register that is valid one cycle after its inputs.
// -----------------------------------------------------------------------------
module lane_traffic_engine #(
  parameter int                   NUM_LANES       = 5,
  parameter int                   OBJ_PER_LANE    = 2,
  parameter int                   GAME_WIDTH      = 14,
  parameter int                   FIRST_LANE_ROW  = 6,
  parameter logic [NUM_LANES-1:0] LANE_DIR_MASK   = 5'b01010,
  parameter logic [NUM_LANES-1:0] LANE_WATER_MASK = 5'b00000,
  parameter int                   CAR_LEN         = 1,
  parameter int                   LOG_LEN         = 3,
  parameter int                   BASE_PERIOD     = 20,
  parameter int                   LANE_STEP       = 4,
  parameter int                   LEVEL_STEP      = 2,
  parameter int                   MIN_PERIOD      = 2,
  parameter int                   LEVEL_W         = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic               i_Frame_Tick,
  input  logic               i_Enable,
  input  logic               i_Restart,
  input  logic [LEVEL_W-1:0] i_Level,
  input  logic [4:0]         i_Query_Col,
  input  logic [4:0]         i_Query_Row,
  output logic               o_Query_Hit,
  output logic               o_Query_Water,
  input  logic [5:0]         i_Frog_X,
  input  logic [5:0]         i_Frog_Y,
  output logic               o_Frog_Collided,
  output logic               o_Frog_On_Log,
  output logic               o_Frog_Drown,
  output logic               o_Carry_Step,
  output logic               o_Carry_Dir
);

  localparam int X_W   = (GAME_WIDTH > 2) ? $clog2(GAME_WIDTH) : 1;
  localparam int CNT_W = 10;

  // Starting column of object k in lane i; lanes are staggered by 3 tiles.
  function automatic logic [X_W-1:0] init_x(input int lane, input int k);
    return X_W'((k * GAME_WIDTH / OBJ_PER_LANE + 3 * lane) % GAME_WIDTH);
  endfunction

  // Effective frames-per-step. Signed int arithmetic so a high level drives the
  // raw value negative instead of wrapping, then the floor applies.
  function automatic logic [CNT_W-1:0] lane_period(input int lane,
                                                   input logic [LEVEL_W-1:0] lvl);
    int p;
    p = BASE_PERIOD + LANE_STEP * lane - LEVEL_STEP * int'(lvl);
    if (p < MIN_PERIOD) p = MIN_PERIOD;
    return CNT_W'(p);
  endfunction

  // An object at x of length len covers x .. x+len-1 modulo the width, so
  // the distance from x forward to col (wrapped) must be below len.
  function automatic logic covers(input logic [X_W-1:0] x, input int len,
                                  input int col);
    int d;
    d = col - int'(x);
    if (d < 0) d = d + GAME_WIDTH;
    return (d < len);
  endfunction

  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x,
                                            input logic right);
    if (right) return (x == X_W'(GAME_WIDTH - 1)) ? '0 : x + X_W'(1);
    else       return (x == '0) ? X_W'(GAME_WIDTH - 1) : x - X_W'(1);
  endfunction

  logic [X_W-1:0]   pos    [NUM_LANES][OBJ_PER_LANE];
  logic [CNT_W-1:0] cnt    [NUM_LANES];
  logic [CNT_W-1:0] period [NUM_LANES];
  logic [NUM_LANES-1:0] lane_step;

  logic q_hit_n, q_water_n, f_col_n, f_log_n, f_drown_n, carry_n, carry_dir_n;
  logic q_cov, f_cov, q_col_ok, f_col_ok;

  // A lane steps on this edge when a live tick finds its counter at or past
  // the last count of the period. The >= keeps a lane from stalling when a
  // level change shortens the period below the current count.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      period[i]    = lane_period(i, i_Level);
      lane_step[i] = i_Frame_Tick && i_Enable && !i_Restart &&
                     (cnt[i] >= period[i] - CNT_W'(1));
    end
  end

  always_comb begin
    q_hit_n     = 1'b0;
    q_water_n   = 1'b0;
    f_col_n     = 1'b0;
    f_log_n     = 1'b0;
    f_drown_n   = 1'b0;
    carry_n     = 1'b0;
    carry_dir_n = 1'b0;
    q_cov       = 1'b0;
    f_cov       = 1'b0;
    q_col_ok    = int'(i_Query_Col) < GAME_WIDTH;
    f_col_ok    = int'(i_Frog_X) < GAME_WIDTH;
    for (int i = 0; i < NUM_LANES; i++) begin
      q_cov = 1'b0;
      f_cov = 1'b0;
      for (int k = 0; k < OBJ_PER_LANE; k++) begin
        q_cov = q_cov | covers(pos[i][k], LANE_WATER_MASK[i] ? LOG_LEN : CAR_LEN,
                               int'(i_Query_Col));
        f_cov = f_cov | covers(pos[i][k], LANE_WATER_MASK[i] ? LOG_LEN : CAR_LEN,
                               int'(i_Frog_X));
      end
      if (int'(i_Query_Row) == FIRST_LANE_ROW + i) begin
        q_hit_n   = q_col_ok && q_cov;
        q_water_n = LANE_WATER_MASK[i];
      end
      if (int'(i_Frog_Y) == FIRST_LANE_ROW + i) begin
        if (f_col_ok) begin
          if (LANE_WATER_MASK[i]) begin
            f_log_n   = f_cov;
            f_drown_n = !f_cov;
          end else begin
            f_col_n   = f_cov;
          end
        end
        // The registered on-log flag describes the frog before this step.
        carry_n     = lane_step[i] && o_Frog_On_Log;
        carry_dir_n = lane_step[i] && o_Frog_On_Log && LANE_DIR_MASK[i];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt[i] <= '0;
        for (int k = 0; k < OBJ_PER_LANE; k++) pos[i][k] <= init_x(i, k);
      end
      o_Query_Hit     <= 1'b0;
      o_Query_Water   <= 1'b0;
      o_Frog_Collided <= 1'b0;
      o_Frog_On_Log   <= 1'b0;
      o_Frog_Drown    <= 1'b0;
      o_Carry_Step    <= 1'b0;
      o_Carry_Dir     <= 1'b0;
    end else begin
      o_Query_Hit     <= q_hit_n;
      o_Query_Water   <= q_water_n;
      o_Frog_Collided <= f_col_n;
      o_Frog_On_Log   <= f_log_n;
      o_Frog_Drown    <= f_drown_n;
      o_Carry_Step    <= carry_n;
      o_Carry_Dir     <= carry_dir_n;
      if (i_Restart) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          cnt[i] <= '0;
          for (int k = 0; k < OBJ_PER_LANE; k++) pos[i][k] <= init_x(i, k);
        end
      end else if (i_Frame_Tick && i_Enable) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_step[i]) begin
            cnt[i] <= '0;
            for (int k = 0; k < OBJ_PER_LANE; k++)
              pos[i][k] <= step_x(pos[i][k], LANE_DIR_MASK[i]);
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_traffic_engine.sv
// -----------------------------------------------------------------------------
// tb_lane_traffic_engine
//
// Two engines share one stimulus stream: index 0 has all-road lanes (default
// parameters), index 1 makes lanes 0 and 1 water (lane 1 moves right). A model
// tracks, per lane, the number of steps taken (mod width) and the frame
// counter, and derives object columns and coverage arithmetically. One
// process compares every output of both engines on every falling edge;
// directed literal checks pin the expected playfield at key points.
// -----------------------------------------------------------------------------
module tb_lane_traffic_engine;

  localparam int W  = 14;
  localparam int NL = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tick, en, rstrt;
  logic [3:0] level;
  logic [4:0] q_col, q_row;
  logic [5:0] fx, fy;
  logic [1:0] o_hit, o_water, o_col, o_log, o_drown, o_carry, o_dir;

  lane_traffic_engine u_road (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Enable(en),
    .i_Restart(rstrt), .i_Level(level), .i_Query_Col(q_col), .i_Query_Row(q_row),
    .o_Query_Hit(o_hit[0]), .o_Query_Water(o_water[0]), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Frog_Collided(o_col[0]), .o_Frog_On_Log(o_log[0]), .o_Frog_Drown(o_drown[0]),
    .o_Carry_Step(o_carry[0]), .o_Carry_Dir(o_dir[0]));

  lane_traffic_engine #(.LANE_WATER_MASK(5'b00011)) u_water (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Enable(en),
    .i_Restart(rstrt), .i_Level(level), .i_Query_Col(q_col), .i_Query_Row(q_row),
    .o_Query_Hit(o_hit[1]), .o_Query_Water(o_water[1]), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Frog_Collided(o_col[1]), .o_Frog_On_Log(o_log[1]), .o_Frog_Drown(o_drown[1]),
    .o_Carry_Step(o_carry[1]), .o_Carry_Dir(o_dir[1]));

  // scoreboard bookkeeping
  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model
  bit [NL-1:0] wmask [2] = '{5'b00000, 5'b00011};
  bit [NL-1:0] dmask = 5'b01010;
  int m_cnt   [2][NL];
  int m_steps [2][NL];
  bit e_hit[2], e_water[2], e_col[2], e_log[2], e_drown[2], e_carry[2], e_dir[2];

  function automatic int lane_of(input int row);
    return (row >= 6 && row < 6 + NL) ? row - 6 : -1;
  endfunction

  function automatic int period(input int lane, input int lvl);
    int p;
    p = 20 + 4 * lane - 2 * lvl;
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int obj_x(input int d, input int lane, input int k);
    int x0;
    x0 = (k * W / 2 + 3 * lane) % W;
    if (dmask[lane]) return (x0 + m_steps[d][lane]) % W;
    return (x0 - m_steps[d][lane] + W) % W;
  endfunction

  function automatic bit is_water(input int d, input int lane);
    return (lane >= 0) && wmask[d][lane];
  endfunction

  function automatic bit covered(input int d, input int lane, input int col);
    int len;
    if (lane < 0 || col >= W) return 1'b0;
    len = is_water(d, lane) ? 3 : 1;
    for (int k = 0; k < 2; k++)
      for (int t = 0; t < len; t++)
        if ((obj_x(d, lane, k) + t) % W == col) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit lane_steps(input int d, input int lane);
    if (lane < 0 || !tick || !en || rstrt) return 1'b0;
    return m_cnt[d][lane] >= period(lane, int'(level)) - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NL; i++) begin
          m_cnt[d][i]   <= 0;
          m_steps[d][i] <= 0;
        end
        e_hit[d] <= 0; e_water[d] <= 0; e_col[d] <= 0; e_log[d] <= 0;
        e_drown[d] <= 0; e_carry[d] <= 0; e_dir[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        e_hit[d]   <= covered(d, lane_of(int'(q_row)), int'(q_col));
        e_water[d] <= is_water(d, lane_of(int'(q_row)));
        e_col[d]   <= covered(d, lane_of(int'(fy)), int'(fx)) &&
                      !is_water(d, lane_of(int'(fy)));
        e_log[d]   <= covered(d, lane_of(int'(fy)), int'(fx)) &&
                      is_water(d, lane_of(int'(fy)));
        e_drown[d] <= is_water(d, lane_of(int'(fy))) && int'(fx) < W &&
                      !covered(d, lane_of(int'(fy)), int'(fx));
        e_carry[d] <= lane_steps(d, lane_of(int'(fy))) && e_log[d];
        e_dir[d]   <= (lane_of(int'(fy)) >= 0) ? dmask[lane_of(int'(fy))] : 1'b0;
        for (int i = 0; i < NL; i++) begin
          if (rstrt) begin
            m_cnt[d][i]   <= 0;
            m_steps[d][i] <= 0;
          end else if (tick && en) begin
            if (m_cnt[d][i] >= period(i, int'(level)) - 1) begin
              m_cnt[d][i]   <= 0;
              m_steps[d][i] <= (m_steps[d][i] + 1) % W;
            end else begin
              m_cnt[d][i] <= m_cnt[d][i] + 1;
            end
          end
        end
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("hit[%0d]", d),      o_hit[d],   e_hit[d]);
        chk($sformatf("water[%0d]", d),    o_water[d], e_water[d]);
        chk($sformatf("collided[%0d]", d), o_col[d],   e_col[d]);
        chk($sformatf("on_log[%0d]", d),   o_log[d],   e_log[d]);
        chk($sformatf("drown[%0d]", d),    o_drown[d], e_drown[d]);
        chk($sformatf("carry[%0d]", d),    o_carry[d], e_carry[d]);
        if (e_carry[d]) chk($sformatf("carry_dir[%0d]", d), o_dir[d], e_dir[d]);
      end
    end
  end

  // driver tasks (always entered and left on a falling edge)
  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic restart_pulse();
    rstrt = 1'b1;
    @(negedge clk);
    rstrt = 1'b0;
  endtask

  task automatic query(input int row, input int col);
    q_row = 5'(row);
    q_col = 5'(col);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; en = 1'b1; rstrt = 1'b0; level = 4'd0;
    q_col = 5'd0; q_row = 5'd0; fx = 6'd40; fy = 6'd40;
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    rst_n = 1'b1;

    // reset state: lane 0 objects at 0 and 7
    query(6, 0);
    chk("rst_road_hit_c0", o_hit[0], 1'b1);
    chk("rst_road_water", o_water[0], 1'b0);
    chk("rst_water_water", o_water[1], 1'b1);
    query(5, 0);
    chk("row5_hit", o_hit[0], 1'b0);

    // 20 ticks at level 0: lane 0 wraps left to 13 and 6, lane 1 unchanged
    ticks(20);
    chk_int("pin_model_l0k0", obj_x(0, 0, 0), 13);
    chk_int("pin_model_l0k1", obj_x(0, 0, 1), 6);
    query(6, 13); chk("t1_c13", o_hit[0], 1'b1);
    query(6, 6);  chk("t1_c6",  o_hit[0], 1'b1);
    query(6, 0);  chk("t1_c0",  o_hit[0], 1'b0);
    query(6, 7);  chk("t1_c7",  o_hit[0], 1'b0);
    query(7, 3);  chk("t1_l1_c3", o_hit[0], 1'b1);

    // level 15: lane 0 period floors at 2
    restart_pulse();
    level = 4'd15;
    ticks(1); query(6, 0);  chk("t2_hold", o_hit[0], 1'b1);
    ticks(1); query(6, 13); chk("t2_step1", o_hit[0], 1'b1);
    ticks(2); query(6, 12); chk("t2_step2", o_hit[0], 1'b1);

    // level rise mid-count steps on the very next tick
    restart_pulse();
    level = 4'd0;
    ticks(10); query(6, 0); chk("t3_before", o_hit[0], 1'b1);
    level = 4'd8;
    ticks(1);
    query(6, 13); chk("t3_after_c13", o_hit[0], 1'b1);
    query(6, 0);  chk("t3_after_c0",  o_hit[0], 1'b0);
    level = 4'd0;

    // disabled: ticks are dropped
    restart_pulse();
    level = 4'd15; en = 1'b0;
    ticks(6);
    query(6, 0); chk("frozen_c0", o_hit[0], 1'b1);
    en = 1'b1;

    // car moves onto the frog: flag one cycle after the position update
    restart_pulse();
    level = 4'd0; fx = 6'd13; fy = 6'd6;
    ticks(20);
    chk("t4_pre", o_col[0], 1'b0);
    @(negedge clk);
    chk("t4_hit", o_col[0], 1'b1);
    fy = 6'd5;
    @(negedge clk);
    chk("t4_off", o_col[0], 1'b0);

    // water lane 0: log at 12 covers 12, 13, 0
    restart_pulse();
    level = 4'd15; fx = 6'd0; fy = 6'd6;
    ticks(4);
    level = 4'd0;
    query(6, 12); chk("t5_c12", o_hit[1], 1'b1);
    query(6, 13); chk("t5_c13", o_hit[1], 1'b1);
    query(6, 0);  chk("t5_c0",  o_hit[1], 1'b1);
    query(6, 1);  chk("t5_c1",  o_hit[1], 1'b0);
    query(6, 14); chk("t5_c14", o_hit[1], 1'b0);
    chk("t5_water", o_water[1], 1'b1);
    chk("t5_on_log", o_log[1], 1'b1);
    chk("t5_no_drown", o_drown[1], 1'b0);
    fx = 6'd1;
    @(negedge clk);
    chk("t5_drown", o_drown[1], 1'b1);
    fx = 6'd20;
    @(negedge clk);
    chk("t5_offgrid_drown", o_drown[1], 1'b0);
    chk("t5_offgrid_log", o_log[1], 1'b0);

    // carry pulse on a right-moving log (lane 1, log at 3..5)
    restart_pulse();
    level = 4'd15; fx = 6'd4; fy = 6'd7;
    repeat (2) @(negedge clk);
    chk("t6_on_log", o_log[1], 1'b1);
    ticks(1); chk("t6_no_carry", o_carry[1], 1'b0);
    ticks(1); chk("t6_carry", o_carry[1], 1'b1); chk("t6_dir", o_dir[1], 1'b1);
    @(negedge clk);
    chk("t6_pulse_end", o_carry[1], 1'b0);
    ticks(1);
    rstrt = 1'b1; tick = 1'b1;
    @(negedge clk);
    rstrt = 1'b0; tick = 1'b0;
    chk("t6_restart_no_carry", o_carry[1], 1'b0);
    query(7, 6); chk("t6_restart_c6", o_hit[1], 1'b0);
    query(7, 3); chk("t6_restart_c3", o_hit[1], 1'b1);

    // asynchronous reset in mid-operation
    ticks(2);
    @(negedge clk);
    chk("ar_on_log_before", o_log[1], 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("ar_on_log", o_log[1], 1'b0);
    chk("ar_water", o_water[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    query(7, 6); chk("ar_pos_c6", o_hit[1], 1'b0);
    query(7, 3); chk("ar_pos_c3", o_hit[1], 1'b1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
